// File: rtl/obi_tb_pkg.sv
// Shared OBI definitions: the memory-target FSM state encoding and the bus word size.
// Also imported by the arbiter bench, so keep it free of target-specific parameters.
package obi_tb_pkg;

    localparam int OBI_WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE,
        GNT_WAIT,
        RESP_WAIT,
        RESP
    } obi_slave_fsm_e;

endpackage

// File: rtl/obi_mem_array.sv
// Byte-enabled single-port synchronous RAM, MEM_WORDS x 32, no reset on contents.
// Read data is registered on an enabled read and holds until the next enabled read.
module obi_mem_array
    import obi_tb_pkg::*;
#(
    parameter int MEM_WORDS = 4096,
    localparam int AW = $clog2(MEM_WORDS)
) (
    input  logic                      clk,
    input  logic                      en,
    input  logic                      wr,
    input  logic [AW-1:0]             addr,
    input  logic [OBI_WORD_BYTES-1:0] be,
    input  logic [31:0]               wdata,
    output logic [31:0]               rdata
);

    logic [31:0] mem [MEM_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            if (wr) begin
                for (int k = 0; k < OBI_WORD_BYTES; k++) begin
                    if (be[k]) begin
                        mem[addr][8*k +: 8] <= wdata[8*k +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/obi_mem_slave.sv
// OBI memory target with programmable grant and response latency; one transfer in flight.
// gnt after GNT_DELAY cycles of req, rvalid exactly RVALID_DELAY cycles after the grant cycle.
module obi_mem_slave
    import obi_tb_pkg::*;
#(
    parameter int          MEM_WORDS    = 4096,
    parameter int          GNT_DELAY    = 0,
    parameter int          RVALID_DELAY = 1,
    parameter logic [31:0] OOB_RDATA    = 32'hDEAD_BEEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  be_i,
    input  logic [3:0]  we_i,
    input  logic [31:0] wdata_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        oob_o,
    output logic        proto_err_o
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int CW = 16;

    obi_slave_fsm_e state;
    logic [CW-1:0]  gcnt;
    logic [CW-1:0]  rcnt;
    logic           resp_wr;
    logic           resp_oob;
    logic           gnt;
    logic           acc_oob;
    logic           acc_wr;
    logic [31:0]    ram_rdata;
    logic           unused_bits;

    assign acc_oob     = (addr_i[31:2] >= 30'(MEM_WORDS));
    assign acc_wr      = |we_i;
    assign unused_bits = ^addr_i[1:0];

    // Grant is combinational so the access lands on the same edge the master sees gnt.
    always_comb begin
        gnt = 1'b0;
        if (!rst_i && req_i) begin
            if (state == IDLE) begin
                gnt = (GNT_DELAY == 0);
            end else if (state == GNT_WAIT) begin
                gnt = (gcnt == '0);
            end
        end
    end

    obi_mem_array #(
        .MEM_WORDS (MEM_WORDS)
    ) u_array (
        .clk   (clk_i),
        .en    (gnt && !acc_oob),
        .wr    (acc_wr),
        .addr  (addr_i[AW+1:2]),
        .be    (be_i),
        .wdata (wdata_i),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            gcnt        <= '0;
            rcnt        <= '0;
            resp_wr     <= 1'b0;
            resp_oob    <= 1'b0;
            oob_o       <= 1'b0;
            proto_err_o <= 1'b0;
        end else if (gnt) begin
            resp_wr  <= acc_wr;
            resp_oob <= acc_oob;
            if (acc_oob) begin
                oob_o <= 1'b1;
            end
            if (RVALID_DELAY == 1) begin
                state <= RESP;
            end else begin
                rcnt  <= CW'(RVALID_DELAY - 2);
                state <= RESP_WAIT;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (req_i) begin
                        gcnt  <= CW'(GNT_DELAY - 1);
                        state <= GNT_WAIT;
                    end
                end
                GNT_WAIT: begin
                    if (!req_i) begin
                        proto_err_o <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        gcnt <= gcnt - 1'b1;
                    end
                end
                RESP_WAIT: begin
                    if (rcnt == '0) begin
                        state <= RESP;
                    end else begin
                        rcnt <= rcnt - 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign gnt_o    = gnt;
    assign rvalid_o = (state == RESP);

    always_comb begin
        rdata_o = '0;
        if (state == RESP && !resp_wr) begin
            rdata_o = resp_oob ? OOB_RDATA : ram_rdata;
        end
    end

endmodule

// File: tb/tb_obi_mem_slave.sv
// Bench for obi_mem_slave: three instances cover (GNT_DELAY,RVALID_DELAY) = (0,1), (3,4), (2,2).
// Expected read data is queued at grant and popped when rvalid is seen.
module tb_obi_mem_slave;

    logic        clk = 1'b0;
    logic [2:0]  rst;
    logic [2:0]  req;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic [2:0]  gnt;
    logic [2:0]  rvalid;
    logic [31:0] rdata [3];
    logic [2:0]  oob;
    logic [2:0]  perr;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    obi_mem_slave #(.GNT_DELAY(0), .RVALID_DELAY(1)) u_a (
        .clk_i(clk), .rst_i(rst[0]), .req_i(req[0]), .addr_i(addr), .be_i(be), .we_i(we),
        .wdata_i(wdata), .gnt_o(gnt[0]), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]),
        .oob_o(oob[0]), .proto_err_o(perr[0]));

    obi_mem_slave #(.GNT_DELAY(3), .RVALID_DELAY(4)) u_b (
        .clk_i(clk), .rst_i(rst[1]), .req_i(req[1]), .addr_i(addr), .be_i(be), .we_i(we),
        .wdata_i(wdata), .gnt_o(gnt[1]), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]),
        .oob_o(oob[1]), .proto_err_o(perr[1]));

    obi_mem_slave #(.GNT_DELAY(2), .RVALID_DELAY(2)) u_c (
        .clk_i(clk), .rst_i(rst[2]), .req_i(req[2]), .addr_i(addr), .be_i(be), .we_i(we),
        .wdata_i(wdata), .gnt_o(gnt[2]), .rvalid_o(rvalid[2]), .rdata_o(rdata[2]),
        .oob_o(oob[2]), .proto_err_o(perr[2]));

    // Called between a negedge and the following posedge; returns in the same phase.
    task automatic xfer(input int d, input logic [31:0] ad, input logic [3:0] b,
                        input logic [3:0] w, input logic [31:0] wd, input logic [31:0] exp_rd,
                        input int exp_gc, input int exp_lat, input bit hold);
        int gc;
        int lat;
        logic [31:0] exp_v;
        addr = ad; be = b; we = w; wdata = wd; req[d] = 1'b1;
        gc = 1;
        #1;
        while (!gnt[d] && gc < 40) begin
            @(negedge clk); #1; gc++;
        end
        tests++;
        if (!gnt[d]) begin
            fails++;
            $display("FAIL gnt_timeout dut%0d addr %h: no gnt in %0d cycles, required at cycle %0d", d, ad, gc, exp_gc);
            req[d] = 1'b0;
            @(negedge clk); #1;
            return;
        end
        if (gc != exp_gc) begin
            fails++;
            $display("FAIL gnt_cycle dut%0d addr %h: gnt in cycle %0d, required %0d", d, ad, gc, exp_gc);
        end
        exp_q.push_back(exp_rd);
        @(posedge clk); #1;
        if (!hold) req[d] = 1'b0;
        lat = 0;
        do begin
            @(negedge clk); #1; lat++;
            tests++;
            if (gnt[d] !== 1'b0) begin
                fails++;
                $display("FAIL gnt_in_resp dut%0d: gnt=%b %0d cycles after grant, required 0", d, gnt[d], lat);
            end
            if (!rvalid[d]) begin
                tests++;
                if (rdata[d] !== 32'h0) begin
                    fails++;
                    $display("FAIL rdata_idle dut%0d: rdata=%h without rvalid, required 0", d, rdata[d]);
                end
            end
        end while (!rvalid[d] && lat < 40);
        tests++;
        if (!rvalid[d]) begin
            fails++;
            $display("FAIL rvalid_timeout dut%0d addr %h: no rvalid in %0d cycles", d, ad, lat);
            void'(exp_q.pop_back());
        end else begin
            if (lat != exp_lat) begin
                fails++;
                $display("FAIL rvalid_latency dut%0d addr %h: rvalid %0d cycles after gnt, required %0d", d, ad, lat, exp_lat);
            end
            exp_v = exp_q.pop_front();
            tests++;
            if (rdata[d] !== exp_v) begin
                fails++;
                $display("FAIL rdata dut%0d addr %h: got %h, required %h", d, ad, rdata[d], exp_v);
            end
        end
        req[d] = hold;
        if (!hold) begin
            @(negedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 3'b111; req = 3'b001; addr = 32'h10; be = 4'hF; we = 4'h0; wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if ({gnt[i], rvalid[i], oob[i], perr[i]} !== 4'b0 || rdata[i] !== 32'h0) begin
                fails++;
                $display("FAIL reset_outputs dut%0d: gnt=%b rvalid=%b oob=%b perr=%b rdata=%h, required all 0",
                         i, gnt[i], rvalid[i], oob[i], perr[i], rdata[i]);
            end
        end
        req = 3'b000;
        rst = 3'b000;
        @(negedge clk); #1;
    endtask

    task automatic test_write_read();
        xfer(0, 32'h10, 4'hF, 4'hF, 32'hA5A5_1234, 32'h0, 1, 1, 1'b0);
        xfer(0, 32'h10, 4'hF, 4'h0, 32'h0, 32'hA5A5_1234, 1, 1, 1'b0);
    endtask

    task automatic test_partial_write();
        xfer(0, 32'h20, 4'hF, 4'hF, 32'hFFFF_FFFF, 32'h0, 1, 1, 1'b0);
        xfer(0, 32'h20, 4'b0101, 4'hF, 32'h1122_3344, 32'h0, 1, 1, 1'b0);
        xfer(0, 32'h20, 4'hF, 4'h0, 32'h0, 32'hFF22_FF44, 1, 1, 1'b0);
    endtask

    // With req held, the next grant must land the cycle after rvalid, never in it.
    task automatic test_back_to_back();
        xfer(0, 32'h10, 4'hF, 4'h0, 32'h0, 32'hA5A5_1234, 1, 1, 1'b1);
        xfer(0, 32'h20, 4'hF, 4'h0, 32'h0, 32'hFF22_FF44, 2, 1, 1'b1);
        xfer(0, 32'h24, 4'hF, 4'hF, 32'h0BAD_CAFE, 32'h0, 2, 1, 1'b0);
        xfer(0, 32'h24, 4'hF, 4'h0, 32'h0, 32'h0BAD_CAFE, 1, 1, 1'b0);
    endtask

    task automatic test_gnt_delay();
        xfer(1, 32'h30, 4'hF, 4'hF, 32'h5A5A_0F0F, 32'h0, 4, 4, 1'b1);
        req[1] = 1'b0;
        @(negedge clk); #1;
        xfer(1, 32'h30, 4'hF, 4'h0, 32'h0, 32'h5A5A_0F0F, 4, 4, 1'b1);
        req[1] = 1'b0;
        @(negedge clk); #1;
    endtask

    task automatic test_oob();
        xfer(0, 32'h0, 4'hF, 4'hF, 32'h1234_5678, 32'h0, 1, 1, 1'b0);
        tests++;
        if (oob[0] !== 1'b0) begin
            fails++;
            $display("FAIL oob_before dut0: oob=%b, required 0", oob[0]);
        end
        xfer(0, 32'h0001_0000, 4'hF, 4'h0, 32'h0, 32'hDEAD_BEEF, 1, 1, 1'b0);
        tests++;
        if (oob[0] !== 1'b1) begin
            fails++;
            $display("FAIL oob_set dut0: oob=%b, required 1", oob[0]);
        end
        xfer(0, 32'h0001_0000, 4'hF, 4'hF, 32'hFFFF_FFFF, 32'h0, 1, 1, 1'b0);
        xfer(0, 32'h0, 4'hF, 4'h0, 32'h0, 32'h1234_5678, 1, 1, 1'b0);
        tests++;
        if (oob[0] !== 1'b1) begin
            fails++;
            $display("FAIL oob_sticky dut0: oob=%b, required 1", oob[0]);
        end
        xfer(1, 32'h0001_0000, 4'hF, 4'h0, 32'h0, 32'hDEAD_BEEF, 4, 4, 1'b0);
        tests++;
        if (oob[1] !== 1'b1) begin
            fails++;
            $display("FAIL oob_set dut1: oob=%b, required 1", oob[1]);
        end
    endtask

    task automatic test_proto_err();
        addr = 32'h80; be = 4'hF; we = 4'h0; req[2] = 1'b1;
        #1;
        tests++;
        if (gnt[2] !== 1'b0) begin
            fails++;
            $display("FAIL proto_early_gnt dut2: gnt=%b in first req cycle, required 0", gnt[2]);
        end
        @(negedge clk); #1;
        req[2] = 1'b0;
        #1;
        tests++;
        if (gnt[2] !== 1'b0) begin
            fails++;
            $display("FAIL proto_gnt dut2: gnt=%b after req dropped, required 0", gnt[2]);
        end
        @(negedge clk); #1;
        tests++;
        if (perr[2] !== 1'b1) begin
            fails++;
            $display("FAIL proto_err dut2: proto_err=%b, required 1", perr[2]);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            tests++;
            if (rvalid[2] !== 1'b0 || gnt[2] !== 1'b0) begin
                fails++;
                $display("FAIL proto_quiet dut2: rvalid=%b gnt=%b, required 0 0", rvalid[2], gnt[2]);
            end
        end
        xfer(2, 32'h80, 4'hF, 4'hF, 32'h7777_0001, 32'h0, 3, 2, 1'b0);
        xfer(2, 32'h80, 4'hF, 4'h0, 32'h0, 32'h7777_0001, 3, 2, 1'b0);
        tests++;
        if (perr[2] !== 1'b1) begin
            fails++;
            $display("FAIL proto_sticky dut2: proto_err=%b, required 1", perr[2]);
        end
    endtask

    task automatic test_reset_mid();
        int gc;
        xfer(1, 32'h40, 4'hF, 4'hF, 32'hCAFE_F00D, 32'h0, 4, 4, 1'b0);
        addr = 32'h40; be = 4'hF; we = 4'h0; req[1] = 1'b1;
        gc = 1;
        #1;
        while (!gnt[1] && gc < 40) begin
            @(negedge clk); #1; gc++;
        end
        tests++;
        if (!gnt[1]) begin
            fails++;
            $display("FAIL abort_gnt_timeout dut1: no gnt in %0d cycles", gc);
        end
        @(posedge clk); #1;
        req[1] = 1'b0;
        @(negedge clk);
        rst[1] = 1'b1;
        @(posedge clk); #1;
        tests++;
        if ({gnt[1], rvalid[1], oob[1], perr[1]} !== 4'b0 || rdata[1] !== 32'h0) begin
            fails++;
            $display("FAIL abort_outputs dut1: gnt=%b rvalid=%b oob=%b perr=%b rdata=%h, required all 0",
                     gnt[1], rvalid[1], oob[1], perr[1], rdata[1]);
        end
        @(negedge clk);
        rst[1] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            tests++;
            if (rvalid[1] !== 1'b0) begin
                fails++;
                $display("FAIL abort_rvalid dut1: rvalid=%b %0d cycles after reset, required 0", rvalid[1], i);
            end
        end
        xfer(1, 32'h40, 4'hF, 4'h0, 32'h0, 32'hCAFE_F00D, 4, 4, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_partial_write();
        test_back_to_back();
        test_gnt_delay();
        test_oob();
        test_proto_err();
        test_reset_mid();
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
